// File: rtl/debug_execution_control_pkg.sv
`default_nettype none
// ============================================================================
// Module   : debug_execution_control_pkg
// Brief    : Shared debug-unit definitions: sequencer state encodings,
//            execution-mode constants and state-bus width.
// Revision : 1.0 - initial release
// ============================================================================
package debug_execution_control_pkg;

  localparam int NB_STATE = 3;

  localparam logic MODE_CONTINUOUS = 1'b0;
  localparam logic MODE_STEP       = 1'b1;

  typedef enum logic [NB_STATE-1:0] {
    ST_IDLE      = 3'd0,
    ST_READY     = 3'd1,
    ST_RUN       = 3'd2,
    ST_STEP_WAIT = 3'd3,
    ST_STEP_EXEC = 3'd4,
    ST_DUMP      = 3'd5,
    ST_DONE      = 3'd6
  } dbg_state_t;

endpackage : debug_execution_control_pkg
`default_nettype wire

// File: rtl/debug_execution_control.sv
`default_nettype none
// ============================================================================
// Module   : debug_execution_control
// Brief    : Debug-mode sequencer for the MIPS pipeline. Gates the global
//            pipeline enable (continuous run or single step), requests a
//            state dump after each step or after a halt, and counts the
//            cycles in which the pipeline was enabled.
// Revision : 1.0 - initial release
// ============================================================================
module debug_execution_control
  import debug_execution_control_pkg::*;
#(
  parameter int NB_COUNT = 32
) (
  input  logic                i_clock,
  input  logic                i_reset,
  input  logic                i_load_done,
  input  logic                i_mode_valid,
  input  logic                i_execution_mode,
  input  logic                i_execution_step,
  input  logic                i_halt,
  input  logic                i_dump_done,
  input  logic                i_restart,
  output logic                o_pipeline_enable,
  output logic                o_dump_start,
  output logic                o_halted,
  output logic [NB_COUNT-1:0] o_cycle_count,
  output logic [NB_STATE-1:0] o_state
);

  dbg_state_t          state_q;
  dbg_state_t          state_d;
  logic                pipeline_enable_q;
  logic                dump_start_q;
  logic                halted_q;
  logic                halt_seen_q;
  logic                mode_step_q;
  logic [NB_COUNT-1:0] count_q;

  // Halt observed for the current dump: sticky flag, or halt sampled in the
  // first dump cycle (which lets a same-cycle dump_done still reach DONE).
  logic w_halt_now;
  assign w_halt_now = halt_seen_q | (dump_start_q & i_halt);

  // Next-state decode.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:      if (i_load_done) state_d = ST_READY;
      ST_READY: begin
        if (i_mode_valid) begin
          state_d = (i_execution_mode == MODE_STEP) ? ST_STEP_WAIT : ST_RUN;
        end
      end
      ST_RUN:       if (i_halt) state_d = ST_DUMP;
      ST_STEP_WAIT: if (i_execution_step) state_d = ST_STEP_EXEC;
      ST_STEP_EXEC: state_d = ST_DUMP;
      ST_DUMP: begin
        if (i_dump_done) begin
          // A continuous-mode dump only ever follows a halt.
          state_d = (!mode_step_q || w_halt_now) ? ST_DONE : ST_STEP_WAIT;
        end
      end
      ST_DONE:      if (i_restart) state_d = ST_IDLE;
      default:      state_d = ST_IDLE;
    endcase
  end

  // State register plus outputs registered from the next state.
  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      state_q           <= ST_IDLE;
      pipeline_enable_q <= 1'b0;
      dump_start_q      <= 1'b0;
      halted_q          <= 1'b0;
      halt_seen_q       <= 1'b0;
      mode_step_q       <= 1'b0;
    end else begin
      state_q           <= state_d;
      pipeline_enable_q <= (state_d == ST_RUN) || (state_d == ST_STEP_EXEC);
      dump_start_q      <= (state_d == ST_DUMP) && (state_q != ST_DUMP);
      halted_q          <= (state_d == ST_DONE);
      if ((state_q == ST_READY) && i_mode_valid) begin
        mode_step_q <= (i_execution_mode == MODE_STEP);
      end
      if ((state_q == ST_DONE) && i_restart) begin
        halt_seen_q <= 1'b0;
      end else if ((state_q == ST_DUMP) && dump_start_q && i_halt) begin
        halt_seen_q <= 1'b1;
      end
    end
  end

  // Enabled-cycle counter: cleared on mode selection, wraps naturally.
  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      count_q <= '0;
    end else if ((state_q == ST_READY) && i_mode_valid) begin
      count_q <= '0;
    end else if (pipeline_enable_q) begin
      count_q <= count_q + NB_COUNT'(1);
    end
  end

  assign o_pipeline_enable = pipeline_enable_q;
  assign o_dump_start      = dump_start_q;
  assign o_halted          = halted_q;
  assign o_cycle_count     = count_q;
  assign o_state           = state_q;

endmodule : debug_execution_control
`default_nettype wire

// File: tb/tb_debug_execution_control.sv
`default_nettype none
// ============================================================================
// Module   : tb_debug_execution_control
// Brief    : Self-checking bench for debug_execution_control: directed
//            scenarios followed by randomized traffic against a behavioural
//            reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_debug_execution_control;

  // Narrow counter so the wrap-around can be exercised in a short run.
  localparam int NB_COUNT = 4;
  localparam int CNT_MOD  = 1 << NB_COUNT;

  logic                i_clock;
  logic                i_reset;
  logic                i_load_done;
  logic                i_mode_valid;
  logic                i_execution_mode;
  logic                i_execution_step;
  logic                i_halt;
  logic                i_dump_done;
  logic                i_restart;
  logic                o_pipeline_enable;
  logic                o_dump_start;
  logic                o_halted;
  logic [NB_COUNT-1:0] o_cycle_count;
  logic [2:0]          o_state;

  debug_execution_control #(.NB_COUNT(NB_COUNT)) u_dut (
    .i_clock          (i_clock),
    .i_reset          (i_reset),
    .i_load_done      (i_load_done),
    .i_mode_valid     (i_mode_valid),
    .i_execution_mode (i_execution_mode),
    .i_execution_step (i_execution_step),
    .i_halt           (i_halt),
    .i_dump_done      (i_dump_done),
    .i_restart        (i_restart),
    .o_pipeline_enable(o_pipeline_enable),
    .o_dump_start     (o_dump_start),
    .o_halted         (o_halted),
    .o_cycle_count    (o_cycle_count),
    .o_state          (o_state)
  );

  initial i_clock = 1'b0;
  always #5 i_clock = ~i_clock;

  int n_checks = 0;
  int n_fail   = 0;
  int n_en     = 0;   // observed enabled cycles
  int n_ds     = 0;   // observed dump-start pulses

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Phase numbers are the documented state encodings.
  localparam int P_IDLE = 0, P_READY = 1, P_RUN = 2, P_WAIT = 3,
                 P_EXEC = 4, P_DUMP = 5, P_DONE = 6;
  int m_phase;
  int m_count;
  int m_dump_age;      // cycles already spent in the current dump
  bit m_step_mode;
  bit m_halt_seen;

  task automatic model_reset();
    m_phase     = P_IDLE;
    m_count     = 0;
    m_dump_age  = 0;
    m_step_mode = 1'b0;
    m_halt_seen = 1'b0;
  endtask

  function automatic bit exp_enable();
    return (m_phase == P_RUN) || (m_phase == P_EXEC);
  endfunction

  task automatic model_edge(input bit ld, input bit mv, input bit md, input bit st,
                            input bit hl, input bit dd, input bit rs);
    int nxt;
    nxt = m_phase;
    if (exp_enable()) m_count = (m_count + 1) % CNT_MOD;
    case (m_phase)
      P_IDLE:  if (ld) nxt = P_READY;
      P_READY: if (mv) begin
        nxt         = md ? P_WAIT : P_RUN;
        m_step_mode = md;
        m_count     = 0;
      end
      P_RUN:   if (hl) nxt = P_DUMP;
      P_WAIT:  if (st) nxt = P_EXEC;
      P_EXEC:  nxt = P_DUMP;
      P_DUMP: begin
        if (m_dump_age == 0 && hl) m_halt_seen = 1'b1;
        if (dd) nxt = (!m_step_mode || m_halt_seen) ? P_DONE : P_WAIT;
      end
      P_DONE:  if (rs) begin
        nxt         = P_IDLE;
        m_halt_seen = 1'b0;
      end
      default: nxt = P_IDLE;
    endcase
    if (nxt == P_DUMP && m_phase == P_DUMP) m_dump_age++;
    else                                    m_dump_age = 0;
    m_phase = nxt;
  endtask

  task automatic compare_outputs();
    check("state",      o_state, m_phase);
    check("enable",     o_pipeline_enable, exp_enable());
    check("dump_start", o_dump_start, (m_phase == P_DUMP) && (m_dump_age == 0));
    check("halted",     o_halted, m_phase == P_DONE);
    check("count",      o_cycle_count, m_count);
  endtask

  // ---------------- stimulus helpers ----------------
  task automatic cycle(input bit ld, input bit mv, input bit md, input bit st,
                       input bit hl, input bit dd, input bit rs);
    i_load_done      = ld;
    i_mode_valid     = mv;
    i_execution_mode = md;
    i_execution_step = st;
    i_halt           = hl;
    i_dump_done      = dd;
    i_restart        = rs;
    @(posedge i_clock);
    model_edge(ld, mv, md, st, hl, dd, rs);
    #1;
    compare_outputs();
    if (o_pipeline_enable) n_en++;
    if (o_dump_start)      n_ds++;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) cycle(0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic do_reset();
    i_load_done = 0; i_mode_valid = 0; i_execution_mode = 0;
    i_execution_step = 0; i_halt = 0; i_dump_done = 0; i_restart = 0;
    i_reset = 1'b0;
    #2;
    model_reset();
    compare_outputs();
    #1;
    i_reset = 1'b1;
  endtask

  int base_en, base_ds;

  initial begin
    i_reset = 1'b1;
    #1;
    do_reset();
    check("rst_state", o_state, 0);
    check("rst_count", o_cycle_count, 0);

    // Continuous run: halt after 10 further enabled cycles.
    base_en = n_en; base_ds = n_ds;
    cycle(1, 0, 0, 0, 0, 0, 0);
    cycle(0, 1, 0, 0, 0, 0, 0);
    idle(10);
    cycle(0, 0, 0, 0, 1, 0, 0);
    check("p1_dump_state", o_state, 5);
    cycle(0, 0, 0, 0, 0, 1, 0);
    check("p1_en_cycles", n_en - base_en, 11);
    check("p1_dumps", n_ds - base_ds, 1);
    check("p1_state", o_state, 6);
    check("p1_halted", o_halted, 1);
    check("p1_count", o_cycle_count, 11);

    // Step mode: three steps, each followed by dump_done.
    cycle(0, 0, 0, 0, 0, 0, 1);
    cycle(1, 0, 0, 0, 0, 0, 0);
    cycle(0, 1, 1, 0, 0, 0, 0);
    base_en = n_en; base_ds = n_ds;
    for (int s = 0; s < 3; s++) begin
      cycle(0, 0, 0, 1, 0, 0, 0);
      cycle(0, 0, 0, 0, 0, 0, 0);
      cycle(0, 0, 0, 0, 0, 1, 0);
    end
    check("p2_en_pulses", n_en - base_en, 3);
    check("p2_dumps", n_ds - base_ds, 3);
    check("p2_state", o_state, 3);
    check("p2_count", o_cycle_count, 3);

    // Step requests during a dump are dropped.
    base_en = n_en;
    cycle(0, 0, 0, 1, 0, 0, 0);
    cycle(0, 0, 0, 0, 0, 0, 0);
    cycle(0, 0, 0, 1, 0, 0, 0);
    cycle(0, 0, 0, 1, 0, 0, 0);
    cycle(0, 0, 0, 0, 0, 1, 0);
    idle(3);
    check("p4_en_pulses", n_en - base_en, 1);
    check("p4_state", o_state, 3);
    check("p4_count", o_cycle_count, 4);

    // Step mode with halt after the second step; same-cycle dump_done.
    do_reset();
    cycle(1, 0, 0, 0, 0, 0, 0);
    cycle(0, 1, 1, 0, 0, 0, 0);
    cycle(0, 0, 0, 1, 0, 0, 0);
    cycle(0, 0, 0, 0, 0, 0, 0);
    cycle(0, 0, 0, 0, 0, 1, 0);
    cycle(0, 0, 0, 1, 0, 0, 0);
    cycle(0, 0, 0, 0, 1, 0, 0);
    cycle(0, 0, 0, 0, 1, 1, 0);
    check("p3_state", o_state, 6);
    check("p3_halted", o_halted, 1);
    for (int s = 0; s < 3; s++) cycle(0, 0, 0, 1, 0, 0, 0);
    check("p3_state_after", o_state, 6);
    check("p3_count", o_cycle_count, 2);

    // Restart, reload, continuous run with counter wrap.
    cycle(0, 0, 0, 0, 0, 0, 1);
    check("p6_idle", o_state, 0);
    cycle(1, 0, 0, 0, 0, 0, 0);
    cycle(0, 1, 0, 0, 0, 0, 0);
    check("p6_count_clr", o_cycle_count, 0);
    idle(20);
    check("p6_count_wrap", o_cycle_count, 20 % CNT_MOD);
    cycle(0, 0, 0, 0, 1, 0, 0);
    cycle(0, 0, 0, 0, 0, 1, 0);
    check("p6_count_end", o_cycle_count, 21 % CNT_MOD);

    // Halt together with mode selection: mode wins, halt acts next.
    cycle(0, 0, 0, 0, 0, 0, 1);
    cycle(1, 0, 0, 0, 0, 0, 0);
    cycle(0, 1, 0, 0, 1, 0, 0);
    check("rh_run", o_state, 2);
    cycle(0, 0, 0, 0, 1, 0, 0);
    check("rh_dump", o_state, 5);
    cycle(0, 0, 0, 0, 0, 1, 0);

    // Asynchronous reset in RUN with count 5.
    cycle(0, 0, 0, 0, 0, 0, 1);
    cycle(1, 0, 0, 0, 0, 0, 0);
    cycle(0, 1, 0, 0, 0, 0, 0);
    idle(5);
    check("p5_pre_count", o_cycle_count, 5);
    base_ds = n_ds;
    do_reset();
    check("p5_state", o_state, 0);
    check("p5_enable", o_pipeline_enable, 0);
    check("p5_dump", o_dump_start, 0);
    check("p5_count", o_cycle_count, 0);
    idle(3);
    check("p5_no_dump", n_ds - base_ds, 0);

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 299) == 0) begin
        do_reset();
      end else begin
        cycle($urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0,
              $urandom_range(0, 1) == 1, $urandom_range(0, 2) == 0,
              $urandom_range(0, 7) == 0, $urandom_range(0, 2) == 0,
              $urandom_range(0, 3) == 0);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_debug_execution_control
`default_nettype wire

// File: doc/debug_execution_control.md
# debug_execution_control

Sequencing controller for the MIPS pipeline in debug mode. Sits between the debug-unit receive path (program load, mode and step commands), the pipeline (global enable, halt flag) and the debug-unit transmit path (state dump). It decides when the pipeline advances: continuous run until halt, or one clock per step command. After a halt in continuous mode, and after every step, it triggers a state dump. It also counts executed cycles.

## Interface
- NB_STATE, 3, width of `o_state`
- NB_COUNT, 32, width of cycle counter
- i_clock  in  1  system clock, rising edge
- i_reset  in  1  asynchronous, active-low reset
- i_load_done  in  1  one-cycle pulse: program load complete (halt word written)
- i_mode_valid  in  1  one-cycle pulse: `i_execution_mode` valid
- i_execution_mode  in  1  1 = step mode, 0 = continuous
- i_execution_step  in  1  one-cycle pulse: step request
- i_halt  in  1  level from pipeline WB stage: halt instruction retired
- i_dump_done  in  1  one-cycle pulse from transmit path: dump finished
- i_restart  in  1  one-cycle pulse: leave DONE, return to IDLE
- o_pipeline_enable  out  1  registered global pipeline enable
- o_dump_start  out  1  registered one-cycle pulse: begin state dump
- o_halted  out  1  high in DONE
- o_cycle_count  out  NB_COUNT  cycles with `o_pipeline_enable` = 1
- o_state  out  NB_STATE  current state encoding

## Operation
- States and encodings: IDLE=0, READY=1, RUN=2, STEP_WAIT=3, STEP_EXEC=4, DUMP=5, DONE=6. Encoding 7 is unreachable and recovers to IDLE.
- IDLE:
  - `i_load_done` → READY.
  - All other inputs ignored.
- READY:
  - `i_mode_valid` with mode 0 → RUN.
  - `i_mode_valid` with mode 1 → STEP_WAIT.
  - Either transition clears `o_cycle_count`.
- RUN:
  - Enable high.
  - `i_halt`=1 → DUMP (enable low from the next cycle).
- STEP_WAIT:
  - Enable low.
  - `i_execution_step` → STEP_EXEC.
- STEP_EXEC:
  - Enable high for exactly one cycle, then unconditionally → DUMP.
- DUMP:
  - Enable low.
  - `o_dump_start` pulses in the first DUMP cycle only.
  - Sticky `halt_seen` captures `i_halt` in that first cycle.
  - `i_dump_done` → DONE if `halt_seen`, else STEP_WAIT.
  - A continuous-mode dump always goes to DONE.
- DONE:
  - `o_halted`=1.
  - `i_restart` → IDLE and clears `halt_seen`.
- Counter increments on every cycle with enable=1 and wraps at 2^NB_COUNT − 1 → 0 without saturation.
- Step pulses outside STEP_WAIT are dropped, not queued. `i_dump_done` outside DUMP is ignored.

## Timing
- Reset values:
  - state=IDLE
  - `o_pipeline_enable`=0, `o_dump_start`=0, `o_halted`=0
  - `o_cycle_count`=0, `halt_seen`=0
- Reset mid-operation aborts immediately, including in RUN or DUMP. No dump is issued.
- All outputs are registered. `o_state` reflects the state one edge after the triggering input.
- Step latency:
  - Step pulse at edge N.
  - Enable high during cycle N+1 only.
  - `o_dump_start` high during cycle N+2.
- Halt in RUN: `i_halt` sampled high at edge N; enable low from cycle N+1; `o_dump_start` in cycle N+1.
- `i_halt` and `i_mode_valid` together in READY: the mode transition wins, and the halt is evaluated in the next state.
- `i_dump_done` in the same cycle as `o_dump_start` is accepted: DUMP lasts one cycle.

## Structure
- State encodings, mode constants (MODE_CONTINUOUS=0, MODE_STEP=1) and NB_STATE belong in the shared debug-unit defs header, also used by the receive/transmit blocks.
- Single module. The cycle counter is inline, with no sub-module.

## Test plan
- Reset then `i_load_done`, mode 0, `i_halt` raised after 10 enabled cycles → enable high exactly 11 cycles (halt cycle counted), one `o_dump_start`, `i_dump_done` → DONE, `o_halted`=1, count=11.
- Mode 1, three step pulses each followed by `i_dump_done` → three single-cycle enable pulses, three dumps, state back to STEP_WAIT (3), count=3.
- Step mode, `i_halt`=1 after second step → dump, then DONE. Further steps ignored, count stays 2.
- Step pulse during DUMP → no enable pulse; after `i_dump_done`, a new step is required.
- `i_reset` low while in RUN with count=5 → all outputs 0, state IDLE, no `o_dump_start`.
- `i_restart` in DONE → IDLE. Reload and continuous run → count restarts from 0.
